// File: rtl/cpu_pkg.sv
// Shared types and constants for the branch/status path: condition codes, FSM states, PC width.
// Pure declarations; no logic, no latency, no flow control.
package cpu_pkg;

    localparam int PC_W_DEFAULT = 9;

    localparam logic [2:0] COND_B   = 3'b000;
    localparam logic [2:0] COND_BEQ = 3'b001;
    localparam logic [2:0] COND_BNE = 3'b010;
    localparam logic [2:0] COND_BLT = 3'b011;
    localparam logic [2:0] COND_BLE = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/status_branch_unit_cond_eval.sv
// Branch condition decode on a set of status flags.
// Purely combinational, no handshake.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_B:   taken = 1'b1;
            COND_BEQ: taken = Z;
            COND_BNE: taken = ~Z;
            COND_BLT: taken = N ^ V;
            COND_BLE: taken = (N ^ V) | Z;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_branch_unit.sv
// Status register, PC and branch FSM: accept -> EVAL -> DONE (pc written entering DONE, done pulses in DONE).
// br_ready only in IDLE, so one branch every 3 cycles; pc_load/pc_inc honoured only in IDLE without an accept.
module status_branch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Z_in,
    input  logic            N_in,
    input  logic            V_in,
    input  logic            loads,
    input  logic            pc_load,
    input  logic [PC_W-1:0] pc_in,
    input  logic            pc_inc,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      cond,
    input  logic [15:0]     sximm8,
    output logic            Z,
    output logic            N,
    output logic            V,
    output logic [PC_W-1:0] pc,
    output logic            done,
    output logic            taken
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            z_q, z_d, n_q, n_d, v_q, v_d;
    logic [2:0]      cond_snap_q, cond_snap_d;
    logic [PC_W-1:0] imm_snap_q, imm_snap_d;
    logic [PC_W-1:0] pc_snap_q, pc_snap_d;
    logic            z_snap_q, z_snap_d, n_snap_q, n_snap_d, v_snap_q, v_snap_d;
    logic            accept;
    logic            cond_taken;
    logic            unused_imm;

    // Only the low PC_W bits of the offset matter; PC arithmetic is modulo 2^PC_W.
    assign unused_imm = ^sximm8;

    cond_eval u_cond_eval (
        .cond  (cond_snap_q),
        .Z     (z_snap_q),
        .N     (n_snap_q),
        .V     (v_snap_q),
        .taken (cond_taken)
    );

    assign br_ready = (state_q == IDLE) & ~reset;
    assign accept   = br_valid & br_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        z_d         = z_q;
        n_d         = n_q;
        v_d         = v_q;
        cond_snap_d = cond_snap_q;
        imm_snap_d  = imm_snap_q;
        pc_snap_d   = pc_snap_q;
        z_snap_d    = z_snap_q;
        n_snap_d    = n_snap_q;
        v_snap_d    = v_snap_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = EVAL;
                    cond_snap_d = cond;
                    imm_snap_d  = sximm8[PC_W-1:0];
                    pc_snap_d   = pc_q;
                    // Pre-edge flags: a loads in the accept cycle must not steer this branch.
                    z_snap_d    = z_q;
                    n_snap_d    = n_q;
                    v_snap_d    = v_q;
                end else if (pc_load) begin
                    pc_d = pc_in;
                end else if (pc_inc) begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            EVAL: begin
                state_d = DONE;
                pc_d    = pc_snap_q + PC_W'(1) + (cond_taken ? imm_snap_q : '0);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (loads) begin
            z_d = Z_in;
            n_d = N_in;
            v_d = V_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            cond_snap_q <= '0;
            imm_snap_q  <= '0;
            pc_snap_q   <= '0;
            z_snap_q    <= 1'b0;
            n_snap_q    <= 1'b0;
            v_snap_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            z_q         <= z_d;
            n_q         <= n_d;
            v_q         <= v_d;
            cond_snap_q <= cond_snap_d;
            imm_snap_q  <= imm_snap_d;
            pc_snap_q   <= pc_snap_d;
            z_snap_q    <= z_snap_d;
            n_snap_q    <= n_snap_d;
            v_snap_q    <= v_snap_d;
        end
    end

    assign Z     = z_q;
    assign N     = n_q;
    assign V     = v_q;
    assign pc    = pc_q;
    assign done  = (state_q == DONE);
    assign taken = (state_q == DONE) & cond_taken;

endmodule

// File: tb/tb_status_branch_unit.sv
// Directed and random stimulus against a timeline-based reference model of status_branch_unit.
module tb_status_branch_unit;

    localparam int PC_W = 9;
    localparam int PCM  = 1 << PC_W;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            Z_in = 1'b0, N_in = 1'b0, V_in = 1'b0, loads = 1'b0;
    logic            pc_load = 1'b0, pc_inc = 1'b0, br_valid = 1'b0;
    logic [PC_W-1:0] pc_in = '0;
    logic [2:0]      cond = 3'b000;
    logic [15:0]     sximm8 = 16'h0000;
    logic            br_ready, Z, N, V, done, taken;
    logic [PC_W-1:0] pc;

    status_branch_unit #(.PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .Z_in(Z_in), .N_in(N_in), .V_in(V_in), .loads(loads),
        .pc_load(pc_load), .pc_in(pc_in), .pc_inc(pc_inc), .br_valid(br_valid),
        .br_ready(br_ready), .cond(cond), .sximm8(sximm8), .Z(Z), .N(N), .V(V),
        .pc(pc), .done(done), .taken(taken)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural PC/flags plus the edge number of the outstanding accept.
    int edge_n   = 0;
    int acc_edge = -1;
    int m_pc     = 0;
    bit m_z = 0, m_n = 0, m_v = 0;
    bit p_taken  = 0;
    int p_target = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit ref_taken(input logic [2:0] c, input bit z, input bit n, input bit v);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return n != v;
            3'd4:    return (n != v) || z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0; m_z = 0; m_n = 0; m_v = 0; acc_edge = -1;
    endtask

    task automatic check_outputs();
        bit exp_done;
        exp_done = (acc_edge >= 0) && (edge_n == acc_edge + 1);
        chk("pc", 32'(pc), 32'(m_pc));
        chk("Z", 32'(Z), 32'(m_z));
        chk("N", 32'(N), 32'(m_n));
        chk("V", 32'(V), 32'(m_v));
        chk("done", 32'(done), 32'(exp_done));
        chk("taken", 32'(taken), 32'(exp_done && p_taken));
        chk("br_ready", 32'(br_ready), 32'((acc_edge < 0) && !reset));
    endtask

    task automatic tick();
        int e;
        bit acc;
        e   = edge_n + 1;
        acc = br_valid && (acc_edge < 0) && !reset;
        @(posedge clk);
        edge_n = e;
        if (reset) begin
            model_reset();
        end else begin
            if (acc_edge >= 0 && e == acc_edge + 1) begin
                m_pc = p_target;
            end else if (acc_edge < 0) begin
                if (acc) begin
                    p_taken  = ref_taken(cond, m_z, m_n, m_v);
                    p_target = (m_pc + 1 + (p_taken ? int'(sximm8) % PCM : 0)) % PCM;
                    acc_edge = e;
                end else if (pc_load) begin
                    m_pc = int'(pc_in);
                end else if (pc_inc) begin
                    m_pc = (m_pc + 1) % PCM;
                end
            end
            if (loads) begin
                m_z = Z_in; m_n = N_in; m_v = V_in;
            end
            if (acc_edge >= 0 && e == acc_edge + 2) acc_edge = -1;
        end
        #1;
        check_outputs();
    endtask

    task automatic assert_reset_async();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
    endtask

    task automatic clear_inputs();
        loads = 0; pc_load = 0; pc_inc = 0; br_valid = 0;
    endtask

    task automatic set_pc(input int v);
        pc_load = 1; pc_in = PC_W'(v); tick(); pc_load = 0;
    endtask

    task automatic set_flags(input bit z, input bit n, input bit v);
        loads = 1; Z_in = z; N_in = n; V_in = v; tick(); loads = 0;
    endtask

    // Issues a branch from IDLE; returns taken as seen during the DONE cycle.
    task automatic branch(input logic [2:0] c, input logic [15:0] imm, output logic t);
        br_valid = 1; cond = c; sximm8 = imm;
        tick();
        clear_inputs();
        tick();
        t = taken;
        tick();
    endtask

    initial begin
        logic t;
        #1;
        model_reset();
        check_outputs();
        reset = 0;
        tick();

        // Reset mid-operation clears PC and flags immediately
        set_pc(5);
        set_flags(1, 1, 1);
        assert_reset_async();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ready", 32'(br_ready), 32'd0);
        tick();
        reset = 0;
        tick();
        chk("ready_after_rst", 32'(br_ready), 32'd1);

        // BEQ taken
        set_flags(1, 0, 0);
        set_pc(10);
        branch(3'b001, 16'h0004, t);
        chk("beq_taken", 32'(t), 32'd1);
        chk("beq_pc", 32'(pc), 32'd15);

        // BLE with negative offset, then BLT not taken
        set_flags(0, 1, 0);
        set_pc(3);
        branch(3'b100, 16'hFFFE, t);
        chk("ble_taken", 32'(t), 32'd1);
        chk("ble_pc", 32'(pc), 32'd2);
        set_flags(0, 1, 1);
        branch(3'b011, 16'h0005, t);
        chk("blt_taken", 32'(t), 32'd0);
        chk("blt_pc", 32'(pc), 32'd3);

        // Wrap-around
        set_pc(511);
        pc_inc = 1; tick(); pc_inc = 0;
        chk("inc_wrap", 32'(pc), 32'd0);
        set_pc(510);
        branch(3'b000, 16'h0001, t);
        chk("b_wrap", 32'(pc), 32'd0);

        // Accept beats pc_load/pc_inc in the same cycle
        set_pc(20);
        pc_inc = 1; pc_load = 1; pc_in = 9'd100;
        branch(3'b000, 16'h0000, t);
        chk("accept_prio_pc", 32'(pc), 32'd21);

        // loads in the accept cycle does not affect the branch
        set_flags(0, 0, 0);
        loads = 1; Z_in = 1;
        branch(3'b001, 16'h0010, t);
        chk("loads_same_cycle_taken", 32'(t), 32'd0);
        chk("loads_same_cycle_Z", 32'(Z), 32'd1);

        // Reset in EVAL aborts the branch
        set_pc(40);
        br_valid = 1; cond = 3'b000; sximm8 = 16'h0008;
        tick();
        clear_inputs();
        assert_reset_async();
        tick();
        reset = 0;
        tick();
        chk("abort_done", 32'(done), 32'd0);
        tick();
        chk("abort_pc", 32'(pc), 32'd0);

        // Reserved condition code
        set_flags(1, 1, 0);
        set_pc(77);
        branch(3'b111, 16'h0003, t);
        chk("rsv_taken", 32'(t), 32'd0);
        chk("rsv_pc", 32'(pc), 32'd78);

        // Random traffic, including br_valid held across DONE and occasional resets
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 59) == 0);
            br_valid = ($urandom_range(0, 3) != 0);
            cond     = 3'($urandom_range(0, 7));
            sximm8   = 16'($urandom);
            loads    = ($urandom_range(0, 2) == 0);
            Z_in     = 1'($urandom); N_in = 1'($urandom); V_in = 1'($urandom);
            pc_load  = ($urandom_range(0, 4) == 0);
            pc_in    = PC_W'($urandom);
            pc_inc   = 1'($urandom);
            tick();
        end
        reset = 0;
        clear_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
